// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - single-issue instruction sequencer driving operand fetch, execute, writeback and branch control
module exec_sequencer #(
    parameter int MULDIV_CYCLES = 4,
    parameter int MEM_LAT       = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] opcode,
    input  logic       am,
    input  logic [2:0] rd,
    input  logic [5:0] br_target,
    input  logic       zero_in,
    input  logic       carry_in,
    input  logic       cmp_in,
    output logic       ex_enable,
    output logic [4:0] ex_opcode,
    output logic       ex_am,
    output logic       rf_we,
    output logic [2:0] rf_waddr,
    output logic       mem_we,
    output logic       pc_load,
    output logic [5:0] pc_target,
    output logic       flush,
    output logic       illegal,
    output logic       halted,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_OPND, S_EXEC, S_MDWAIT, S_WB, S_HALT
    } state_t;

    localparam logic [3:0] MD_LOAD = 4'(MULDIV_CYCLES - 2);
    localparam logic [1:0] OP_LOAD = 2'(MEM_LAT - 1);

    state_t     state, state_nxt;
    logic [4:0] opcode_q;
    logic       am_q;
    logic [2:0] rd_q;
    logic [5:0] tgt_q;
    logic       z_q, c_q, k_q;
    logic [3:0] md_cnt;
    logic [1:0] op_cnt;

    logic accept;
    logic is_muldiv, is_alu, writes_rf, is_store, is_cmp, is_illegal, is_halt, take;

    assign accept = (state == S_IDLE) && in_valid;

    // Opcode classes, all decoded from the latched copy of the instruction
    assign is_muldiv  = (opcode_q == 5'd3) || (opcode_q == 5'd4);
    assign is_alu     = (opcode_q <= 5'd10) || ((opcode_q >= 5'd16) && (opcode_q <= 5'd21));
    assign writes_rf  = (opcode_q <= 5'd11) || ((opcode_q >= 5'd16) && (opcode_q <= 5'd21));
    assign is_store   = (opcode_q == 5'd12);
    assign is_cmp     = (opcode_q == 5'd25);
    assign is_illegal = (opcode_q == 5'd15) || ((opcode_q >= 5'd26) && (opcode_q <= 5'd30));
    assign is_halt    = (opcode_q == 5'd31);

    always_comb begin
        case (opcode_q)
            5'd13:   take = 1'b1;
            5'd14:   take = z_q;
            5'd22:   take = ~z_q;
            5'd23:   take = c_q;
            5'd24:   take = k_q;
            default: take = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            opcode_q <= '0;
            am_q     <= 1'b0;
            rd_q     <= '0;
            tgt_q    <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            k_q      <= 1'b0;
            md_cnt   <= '0;
            op_cnt   <= '0;
        end else begin
            if (accept) begin
                opcode_q <= opcode;
                am_q     <= am;
                rd_q     <= rd;
                tgt_q    <= br_target;
                op_cnt   <= OP_LOAD;
            end else if (state == S_OPND && op_cnt != 2'd0) begin
                op_cnt <= op_cnt - 2'd1;
            end
            // EXEC counts as the first execute cycle, so MDWAIT runs MULDIV_CYCLES-1 cycles
            if (state == S_EXEC && is_muldiv)
                md_cnt <= MD_LOAD;
            else if (state == S_MDWAIT && md_cnt != 4'd0)
                md_cnt <= md_cnt - 4'd1;
            if (state == S_WB) begin
                if (is_alu) begin
                    z_q <= zero_in;
                    c_q <= carry_in;
                end
                if (is_cmp) k_q <= cmp_in;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        ex_enable = 1'b0;
        rf_we     = 1'b0;
        mem_we    = 1'b0;
        pc_load   = 1'b0;
        flush     = 1'b0;
        illegal   = 1'b0;
        halted    = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = (am || opcode == 5'd11) ? S_OPND : S_EXEC;
            end
            S_OPND: begin
                busy = 1'b1;
                if (op_cnt == 2'd0) state_nxt = S_EXEC;
            end
            S_EXEC: begin
                busy      = 1'b1;
                ex_enable = 1'b1;
                state_nxt = is_muldiv ? S_MDWAIT : S_WB;
            end
            S_MDWAIT: begin
                busy      = 1'b1;
                ex_enable = 1'b1;
                if (md_cnt == 4'd0) state_nxt = S_WB;
            end
            S_WB: begin
                busy      = 1'b1;
                rf_we     = writes_rf;
                mem_we    = is_store;
                pc_load   = take;
                flush     = take;
                illegal   = is_illegal;
                state_nxt = is_halt ? S_HALT : S_IDLE;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign ex_opcode = opcode_q;
    assign ex_am     = am_q;
    assign rf_waddr  = rd_q;
    assign pc_target = tgt_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// tb/tb_exec_sequencer.sv - directed self-checking bench for exec_sequencer
module tb_exec_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] opcode = '0;
    logic       am = 1'b0;
    logic [2:0] rd = '0;
    logic [5:0] br_target = '0;
    logic       zero_in = 1'b0, carry_in = 1'b0, cmp_in = 1'b0;
    logic       ex_enable, ex_am, rf_we, mem_we, pc_load, flush, illegal, halted, busy;
    logic [4:0] ex_opcode;
    logic [2:0] rf_waddr;
    logic [5:0] pc_target;

    int n_checks = 0;
    int n_fail   = 0;

    exec_sequencer #(.MULDIV_CYCLES(4), .MEM_LAT(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .am(am), .rd(rd), .br_target(br_target),
        .zero_in(zero_in), .carry_in(carry_in), .cmp_in(cmp_in),
        .ex_enable(ex_enable), .ex_opcode(ex_opcode), .ex_am(ex_am),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .mem_we(mem_we),
        .pc_load(pc_load), .pc_target(pc_target), .flush(flush),
        .illegal(illegal), .halted(halted), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction in IDLE; returns one cycle after acceptance
    task automatic issue(input logic [4:0] op, input logic a, input logic [2:0] r, input logic [5:0] t);
        opcode = op; am = a; rd = r; br_target = t; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] got;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        got = {in_ready, halted, busy, ex_enable, rf_we, mem_we, pc_load, flush, illegal, ex_am};
        n_checks++;
        if (got !== 10'b10_0000_0000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected %b", got, 10'b10_0000_0000);
        end
        n_checks++;
        if ({ex_opcode, rf_waddr, pc_target} !== 14'd0) begin
            n_fail++; $display("FAIL reset_regs: got %h expected 0", {ex_opcode, rf_waddr, pc_target});
        end
    endtask

    task automatic test_add();
        issue(5'd1, 1'b0, 3'd3, 6'd0);
        n_checks++;
        if ({ex_enable, busy, in_ready} !== 3'b110) begin
            n_fail++; $display("FAIL add_exec: got %b expected 110", {ex_enable, busy, in_ready});
        end
        step();
        n_checks++;
        if ({rf_we, rf_waddr, ex_enable, mem_we} !== {1'b1, 3'd3, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL add_wb: got %b expected 1011_0_0", {rf_we, rf_waddr, ex_enable, mem_we});
        end
        step();
        n_checks++;
        if ({in_ready, busy, rf_we} !== 3'b100) begin
            n_fail++; $display("FAIL add_idle: got %b expected 100", {in_ready, busy, rf_we});
        end
    endtask

    task automatic test_mul_mem();
        logic [7:0] ee, bb, ww;
        logic       opnd_ok;
        ee = '0; bb = '0; ww = '0;
        issue(5'd3, 1'b1, 3'd5, 6'd0);
        opnd_ok = (ex_am === 1'b1) && (ex_opcode === 5'd3);
        for (int i = 0; i < 8; i++) begin
            ee[i] = ex_enable; bb[i] = busy; ww[i] = rf_we;
            step();
        end
        n_checks++;
        if (!opnd_ok) begin
            n_fail++; $display("FAIL mul_latched: got am=%b op=%0d expected am=1 op=3", ex_am, ex_opcode);
        end
        n_checks++;
        if (ee !== 8'b0001_1110) begin
            n_fail++; $display("FAIL mul_ex_enable: got %b expected 00011110", ee);
        end
        n_checks++;
        if (bb !== 8'b0011_1111) begin
            n_fail++; $display("FAIL mul_busy: got %b expected 00111111", bb);
        end
        n_checks++;
        if (ww !== 8'b0010_0000) begin
            n_fail++; $display("FAIL mul_rf_we: got %b expected 00100000", ww);
        end
    endtask

    task automatic test_branch();
        zero_in = 1'b1;
        issue(5'd2, 1'b0, 3'd1, 6'd0);
        step(); step();
        zero_in = 1'b0;
        issue(5'd14, 1'b0, 3'd0, 6'h2A);
        step();
        n_checks++;
        if ({pc_load, flush, pc_target, rf_we} !== {1'b1, 1'b1, 6'h2A, 1'b0}) begin
            n_fail++; $display("FAIL beq_taken: got %b expected 11_101010_0", {pc_load, flush, pc_target, rf_we});
        end
        step();
        issue(5'd2, 1'b0, 3'd1, 6'd0);
        step(); step();
        issue(5'd14, 1'b0, 3'd0, 6'h2A);
        step();
        n_checks++;
        if ({pc_load, flush} !== 2'b00) begin
            n_fail++; $display("FAIL beq_not_taken: got %b expected 00", {pc_load, flush});
        end
        step();
        issue(5'd22, 1'b0, 3'd0, 6'h15);
        step();
        n_checks++;
        if ({pc_load, flush, pc_target} !== {2'b11, 6'h15}) begin
            n_fail++; $display("FAIL bnz_taken: got %b expected 11_010101", {pc_load, flush, pc_target});
        end
        step();
    endtask

    task automatic test_store_illegal();
        logic [3:0] mw, rw, il, other;
        mw = '0; rw = '0; il = '0; other = '0;
        issue(5'd12, 1'b0, 3'd2, 6'd0);
        for (int i = 0; i < 4; i++) begin
            mw[i] = mem_we; rw[i] = rf_we;
            step();
        end
        n_checks++;
        if ({mw, rw} !== 8'b0010_0000) begin
            n_fail++; $display("FAIL store_strobes: got mem_we=%b rf_we=%b expected 0010 0000", mw, rw);
        end
        issue(5'd27, 1'b0, 3'd2, 6'h3F);
        for (int i = 0; i < 4; i++) begin
            il[i] = illegal; other[i] = rf_we | mem_we | pc_load | flush;
            step();
        end
        n_checks++;
        if ({il, other} !== 8'b0010_0000) begin
            n_fail++; $display("FAIL illegal_strobes: got illegal=%b other=%b expected 0010 0000", il, other);
        end
    endtask

    task automatic test_halt();
        issue(5'd31, 1'b0, 3'd0, 6'd0);
        step(); step();
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if ({halted, in_ready, busy, ex_enable, rf_we} !== 5'b10000) begin
                n_fail++; $display("FAIL halt_cycle%0d: got %b expected 10000", i, {halted, in_ready, busy, ex_enable, rf_we});
            end
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0;
        n_checks++;
        if ({halted, in_ready, busy} !== 3'b010) begin
            n_fail++; $display("FAIL halt_reset: got %b expected 010", {halted, in_ready, busy});
        end
    endtask

    task automatic test_reset_mdwait();
        int rf_count;
        zero_in = 1'b1;
        issue(5'd2, 1'b0, 3'd1, 6'd0);
        step(); step();
        zero_in = 1'b0;
        issue(5'd4, 1'b0, 3'd6, 6'd0);
        step(); step();
        n_checks++;
        if ({ex_enable, busy} !== 2'b11) begin
            n_fail++; $display("FAIL div_mdwait: got %b expected 11", {ex_enable, busy});
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if ({in_ready, busy, ex_enable, rf_we, halted, ex_opcode, rf_waddr} !== {5'b10000, 5'd0, 3'd0}) begin
            n_fail++; $display("FAIL mdwait_reset: got %b expected 10000_00000_000",
                               {in_ready, busy, ex_enable, rf_we, halted, ex_opcode, rf_waddr});
        end
        rf_count = 0;
        for (int i = 0; i < 6; i++) begin
            if (rf_we === 1'b1) rf_count++;
            step();
        end
        n_checks++;
        if (rf_count !== 0) begin
            n_fail++; $display("FAIL mdwait_no_rf_we: got %0d expected 0", rf_count);
        end
        issue(5'd14, 1'b0, 3'd0, 6'h2A);
        step();
        n_checks++;
        if (pc_load !== 1'b0) begin
            n_fail++; $display("FAIL z_cleared_by_reset: got pc_load=%b expected 0", pc_load);
        end
        step();
    endtask

    initial begin
        #1;
        test_reset();
        test_add();
        test_mul_mem();
        test_branch();
        test_store_illegal();
        test_halt();
        test_reset_mdwait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
